// File: rtl/spi_sd_port_pkg.sv
// Shared definitions for the SD-card SPI port: register offsets, STAT bit positions
// and the shift-engine state encoding.
package spi_sd_port_pkg;

  // Register offsets within the 0x7000-0x7003 window
  localparam logic [1:0] SpiData = 2'd0;
  localparam logic [1:0] SpiStat = 2'd1;
  localparam logic [1:0] SpiDiv  = 2'd2;
  localparam logic [1:0] SpiCsr  = 2'd3;

  // STAT bit positions
  localparam int unsigned StatBusy = 7;
  localparam int unsigned StatDone = 6;
  localparam int unsigned StatOvr  = 5;
  localparam int unsigned StatIe   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } spi_state_e;

endpackage

// File: rtl/spi_sd_port_if.sv
// CPU-side bus of the SD SPI port: chip select, write strobe, register select,
// write data, combinational read data and the active-low interrupt.
interface spi_sd_port_if;

  logic       cs;
  logic       we;
  logic [1:0] rs;
  logic [7:0] di;
  logic [7:0] rdata;
  logic       irq_n;

  modport master (
    output cs, we, rs, di,
    input  rdata, irq_n
  );

  modport slave (
    input  cs, we, rs, di,
    output rdata, irq_n
  );

endinterface

// File: rtl/spi_sd_port_shift_engine.sv
// Mode-0 SPI shift engine: half-period divider, IDLE/LOW/HIGH/DONE sequencer,
// MSB-first TX/RX shift registers and the MISO synchronizer.
module spi_sd_port_shift_engine
  import spi_sd_port_pkg::*;
#(
  parameter logic [7:0] FillByte = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] tx_i,
  input  logic [7:0] div_i,
  input  logic       miso_i,
  output logic       busy_o,
  output logic       done_pulse_o,
  output logic [7:0] rx_o,
  output logic       sclk_o,
  output logic       mosi_o
);

  spi_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [2:0] bit_q, bit_d;
  logic       sclk_q, sclk_d;
  logic       miso_meta_q, miso_sync_q;

  // Two-flop synchronizer on the asynchronous card MISO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miso_meta_q <= 1'b1;
      miso_sync_q <= 1'b1;
    end else begin
      miso_meta_q <= miso_i;
      miso_sync_q <= miso_meta_q;
    end
  end

  // Sequencer, divider and shift-register state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      tx_q    <= FillByte;
      rx_q    <= 8'h00;
      bit_q   <= 3'd0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
    end
  end

  // Next-state: each phase lasts div+1 cycles; div is sampled only at reload
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_d        = bit_q;
    sclk_d       = sclk_q;
    done_pulse_o = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          state_d = StLow;
          cnt_d   = div_i;
          tx_d    = tx_i;
          bit_d   = 3'd0;
        end
      end
      StLow: begin
        if (cnt_q == 8'd0) begin
          state_d = StHigh;
          cnt_d   = div_i;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], miso_sync_q};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHigh: begin
        if (cnt_q == 8'd0) begin
          cnt_d  = div_i;
          sclk_d = 1'b0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            // Done is flagged on the same edge busy drops
            state_d      = StDone;
            tx_d         = FillByte;
            done_pulse_o = 1'b1;
          end else begin
            state_d = StLow;
            tx_d    = {tx_q[6:0], FillByte[7]};
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q == StLow) || (state_q == StHigh);
  assign rx_o   = rx_q;
  assign sclk_o = sclk_q;
  // tx_q holds the fill byte whenever no transfer is running
  assign mosi_o = tx_q[7];

endmodule

// File: rtl/spi_sd_port.sv
// SD-card SPI master on the 65C02 bus: DATA/STAT/DIV/CSR register file, combinational
// read mux and interrupt, wrapped around the shift engine.
module spi_sd_port
  import spi_sd_port_pkg::*;
#(
  parameter logic [7:0] DivReset = 8'd67,
  parameter logic [7:0] FillByte = 8'hFF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  spi_sd_port_if.slave cpu,
  output logic         sd_clk_o,
  output logic         sd_cs_o,
  output logic         sd_mosi_o,
  input  logic         sd_miso_i
);

  logic [7:0] div_q, div_d;
  logic       ie_q, ie_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       sd_cs_q, sd_cs_d;

  logic       wr_en, data_acc, start, busy, done_pulse;
  logic [7:0] rx;

  assign wr_en    = cpu.cs & cpu.we;
  assign data_acc = cpu.cs & (cpu.rs == SpiData);
  assign start    = wr_en & (cpu.rs == SpiData) & ~busy;

  spi_sd_port_shift_engine #(
    .FillByte (FillByte)
  ) u_engine (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start),
    .tx_i         (cpu.di),
    .div_i        (div_q),
    .miso_i       (sd_miso_i),
    .busy_o       (busy),
    .done_pulse_o (done_pulse),
    .rx_o         (rx),
    .sclk_o       (sd_clk_o),
    .mosi_o       (sd_mosi_o)
  );

  // Bus-visible register state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= DivReset;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sd_cs_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      sd_cs_q <= sd_cs_d;
    end
  end

  // Register writes; any DATA access clears done, but a completing transfer wins
  always_comb begin
    div_d   = div_q;
    ie_d    = ie_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    sd_cs_d = sd_cs_q;
    if (wr_en) begin
      unique case (cpu.rs)
        SpiData: if (busy) ovr_d = 1'b1;
        SpiStat: begin
          ie_d = cpu.di[StatIe];
          if (cpu.di[StatOvr])  ovr_d  = 1'b0;
          if (cpu.di[StatDone]) done_d = 1'b0;
        end
        SpiDiv:  div_d   = cpu.di;
        SpiCsr:  sd_cs_d = cpu.di[0];
        default: ;
      endcase
    end
    if (data_acc)   done_d = 1'b0;
    if (done_pulse) done_d = 1'b1;
  end

  // Combinational read mux
  always_comb begin
    cpu.rdata = 8'h00;
    unique case (cpu.rs)
      SpiData: cpu.rdata = rx;
      SpiStat: cpu.rdata = {busy, done_q, ovr_q, 4'b0000, ie_q};
      SpiDiv:  cpu.rdata = div_q;
      SpiCsr:  cpu.rdata = {7'b0000000, sd_cs_q};
      default: cpu.rdata = 8'h00;
    endcase
  end

  assign cpu.irq_n = ~(done_q & ie_q);
  assign sd_cs_o   = sd_cs_q;

endmodule
